im_loader: RTL

Boot-time writer for the instruction SRAM. The pipeline core only reads this memory, through the im port at current_pc[15:0]; this block is the write side of that port. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into instruction memory. It holds the core in reset until the whole image has been loaded.

---
 rtl/im_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory writer.
// Assembles a little-endian byte stream into words and holds the core in reset until the image is written.
module im_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [3:0]  im_w_en,
    output logic [15:0] im_address,
    output logic [31:0] im_write_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, next;

    logic [1:0]  byte_idx;
    logic [31:0] len_q;
    logic [23:0] word_q;

    logic        take;
    logic        last;
    logic [31:0] len_full;
    logic [31:0] word_full;
    logic [35:0] span;
    logic [31:0] ww_inc;

    logic        ready_d;
    logic [3:0]  wen_d;
    logic [15:0] addr_d;
    logic [31:0] data_d;
    logic        hold_d;
    logic        done_d;
    logic        err_d;

    assign take      = in_valid && in_ready;
    assign last      = take && (byte_idx == 2'd3);
    assign len_full  = {in_data, len_q[23:0]};
    assign word_full = {in_data, word_q};
    // Wide enough that 4*N can never overflow before the bound check.
    assign span      = 36'(BASE_ADDR) + {2'b00, len_full, 2'b00};
    assign ww_inc    = 32'(words_written) + 32'd1;

    // State register and datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_LEN;
            byte_idx      <= 2'd0;
            len_q         <= 32'd0;
            word_q        <= 24'd0;
            words_written <= 16'd0;
            in_ready      <= 1'b0;
            im_w_en       <= 4'h0;
            im_address    <= BASE_ADDR;
            im_write_data <= 32'd0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= next;
            in_ready      <= ready_d;
            im_w_en       <= wen_d;
            im_address    <= addr_d;
            im_write_data <= data_d;
            cpu_hold      <= hold_d;
            done          <= done_d;
            error         <= err_d;
            if (take) begin
                byte_idx <= byte_idx + 2'd1;
                if (state == S_LEN) begin
                    unique case (byte_idx)
                        2'd0: len_q[7:0]   <= in_data;
                        2'd1: len_q[15:8]  <= in_data;
                        2'd2: len_q[23:16] <= in_data;
                        2'd3: len_q[31:24] <= in_data;
                    endcase
                end else begin
                    unique case (byte_idx)
                        2'd0: word_q[7:0]   <= in_data;
                        2'd1: word_q[15:8]  <= in_data;
                        2'd2: word_q[23:16] <= in_data;
                        default: ;
                    endcase
                end
            end
            if (state == S_WRITE)
                words_written <= words_written + 16'd1;
        end
    end

    // Next-state logic
    always_comb begin
        next = state;
        unique case (state)
            S_LEN: begin
                if (last) begin
                    if (len_full == 32'd0)
                        next = S_DONE;
                    else if (len_full > 32'(MAX_WORDS) ||
                             span > 36'd65536)
                        next = S_ERR;
                    else
                        next = S_DATA;
                end
            end
            S_DATA: begin
                if (last)
                    next = S_WRITE;
            end
            S_WRITE: begin
                next = (ww_inc == len_q) ? S_DONE : S_DATA;
            end
            S_DONE:  next = S_DONE;
            S_ERR:   next = S_ERR;
            default: next = S_LEN;
        endcase
    end

    // Registered outputs are computed from the upcoming state
    always_comb begin
        ready_d = (next == S_LEN) || (next == S_DATA);
        wen_d   = (next == S_WRITE) ? 4'hF : 4'h0;
        addr_d  = im_address;
        data_d  = im_write_data;
        hold_d  = (next != S_DONE);
        done_d  = (next == S_DONE);
        err_d   = (next == S_ERR);
        if (next == S_WRITE && state != S_WRITE) begin
            addr_d = BASE_ADDR + (words_written << 2);
            data_d = word_full;
        end
    end

endmodule
